// File: rtl/fios_seq_pkg.sv
// Shared types and constants for the FIOS operand sequencer slice.
package fios_seq_pkg;

    localparam int WORD_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_A  = 2'd0,
        SEL_B  = 2'd1,
        SEL_P  = 2'd2,
        SEL_P0 = 2'd3
    } wr_sel_t;

    // Number of A windows needed to cover n words with d words per window.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/fios_operand_sequencer_if.sv
// Sequencer <-> FIOS core link. "master" is the sequencer side, "slave" the core side.
interface fios_operand_sequencer_if #(
    parameter int PE_NB = 8
);
    import fios_seq_pkg::*;

    logic                      core_start_o;
    logic [WORD_W-1:0]         core_p_prime_0_o;
    logic [PE_NB*WORD_W-1:0]   core_a_o;
    logic [WORD_W-1:0]         core_b_o;
    logic [WORD_W-1:0]         core_p_o;
    logic                      core_a_shift_i;
    logic                      core_b_fetch_i;
    logic                      core_p_fetch_i;
    logic                      core_res_push_i;
    logic [WORD_W-1:0]         core_res_i;
    logic                      core_done_i;

    modport master (
        output core_start_o, core_p_prime_0_o, core_a_o, core_b_o, core_p_o,
        input  core_a_shift_i, core_b_fetch_i, core_p_fetch_i,
               core_res_push_i, core_res_i, core_done_i
    );

    modport slave (
        input  core_start_o, core_p_prime_0_o, core_a_o, core_b_o, core_p_o,
        output core_a_shift_i, core_b_fetch_i, core_p_fetch_i,
               core_res_push_i, core_res_i, core_done_i
    );

endinterface

// File: rtl/fios_word_buffer.sv
// DEPTH x 17-bit word store with one write port and a registered read port
// that returns WIN consecutive words from rd_base_i (out-of-range words read 0).
module fios_word_buffer
    import fios_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIN   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [WORD_W-1:0]       wr_data_i,
    input  logic                    rd_en_i,
    input  logic [31:0]             rd_base_i,
    output logic [WIN*WORD_W-1:0]   rd_data_o
);

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [WIN*WORD_W-1:0] win_d;
    logic [WIN*WORD_W-1:0] rd_q;

    // Word storage; the caller guarantees wr_addr_i < DEPTH when writing.
    // NOTE: the array has no reset so it maps onto plain storage; contents survive reset by design.
    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Gather the window, zero-filling words that fall past the end of the buffer.
    // NOTE: win_d gets a full default first so no path leaves it unassigned (no latch).
    always_comb begin
        win_d = '0;
        for (int k = 0; k < WIN; k++) begin
            if (rd_base_i + 32'(k) < 32'(DEPTH)) begin
                win_d[k*WORD_W +: WORD_W] = mem_q[AW'(rd_base_i + 32'(k))];
            end
        end
    end

    // Registered read port; holds its value while rd_en_i is low.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= win_d;
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/fios_operand_sequencer.sv
// Front end of the FIOS 3A Montgomery core: holds A/B/P/P'0 and the result
// buffer, launches one multiplication and feeds the core's fetch/shift strobes.
module fios_operand_sequencer
    import fios_seq_pkg::*;
#(
    parameter int s      = 8,
    parameter int PE_NB  = 8,
    parameter int ADDR_W = $clog2(s)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                wr_en_i,
    input  logic [1:0]          wr_sel_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [WORD_W-1:0]   wr_data_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [WORD_W-1:0]   rd_data_o,
    fios_operand_sequencer_if.master core
);

    localparam int A_WINS  = ceil_div(s, PE_NB);
    localparam int A_PTR_W = (A_WINS > 1) ? $clog2(A_WINS) : 1;
    localparam int RES_W   = $clog2(s + 1);

    state_t              state_q, state_d;
    logic [A_PTR_W-1:0]  a_ptr_q, a_ptr_d;
    logic [ADDR_W-1:0]   b_ptr_q, b_ptr_d;
    logic [ADDR_W-1:0]   p_ptr_q, p_ptr_d;
    logic [RES_W-1:0]    res_ptr_q, res_ptr_d;
    logic                err_q, err_d;
    logic                core_start_q;
    logic [WORD_W-1:0]   p0_q;
    logic                wr_ok, wr_err, res_we, feed_en;
    wr_sel_t             wr_sel;

    assign wr_sel  = wr_sel_t'(wr_sel_i);
    assign busy_o  = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);
    assign err_o   = err_q;
    assign feed_en = busy_o;

    // Host write qualification: only IDLE accepts; busy writes and bad addresses flag an error.
    always_comb begin
        wr_ok  = 1'b0;
        wr_err = 1'b0;
        if (wr_en_i) begin
            if (state_q != ST_IDLE) begin
                wr_err = busy_o;
            end else if (wr_sel != SEL_P0 && 32'(wr_addr_i) >= 32'(s)) begin
                wr_err = 1'b1;
            end else begin
                wr_ok = 1'b1;
            end
        end
    end

    // Next-state, pointer and error logic for the IDLE/ARM/RUN/DONE sequence.
    always_comb begin
        state_d   = state_q;
        a_ptr_d   = a_ptr_q;
        b_ptr_d   = b_ptr_q;
        p_ptr_d   = p_ptr_q;
        res_ptr_d = res_ptr_q;
        err_d     = err_q;
        res_we    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_ARM;
                    err_d     = 1'b0;
                    a_ptr_d   = '0;
                    b_ptr_d   = '0;
                    p_ptr_d   = '0;
                    res_ptr_d = '0;
                end
            end
            ST_ARM: state_d = ST_RUN;
            ST_RUN: begin
                if (core.core_b_fetch_i) begin
                    b_ptr_d = (32'(b_ptr_q) == 32'(s - 1)) ? '0 : b_ptr_q + 1'b1;
                end
                if (core.core_p_fetch_i) begin
                    p_ptr_d = (32'(p_ptr_q) == 32'(s - 1)) ? '0 : p_ptr_q + 1'b1;
                end
                if (core.core_a_shift_i) begin
                    a_ptr_d = (32'(a_ptr_q) == 32'(A_WINS - 1)) ? '0 : a_ptr_q + 1'b1;
                end
                // A push in the done cycle is counted before the completeness check.
                if (core.core_res_push_i) begin
                    if (32'(res_ptr_q) < 32'(s)) begin
                        res_we    = 1'b1;
                        res_ptr_d = res_ptr_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (core.core_done_i) begin
                    state_d = ST_DONE;
                    if (32'(res_ptr_d) != 32'(s)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (wr_err) begin
            err_d = 1'b1;
        end
    end

    // State, pointer and flag registers; reset aborts any run on the same edge.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            a_ptr_q      <= '0;
            b_ptr_q      <= '0;
            p_ptr_q      <= '0;
            res_ptr_q    <= '0;
            err_q        <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_ptr_q      <= a_ptr_d;
            b_ptr_q      <= b_ptr_d;
            p_ptr_q      <= p_ptr_d;
            res_ptr_q    <= res_ptr_d;
            err_q        <= err_d;
            core_start_q <= (state_q == ST_ARM);
        end
    end

    // P'0 is operand storage like the buffers, so it is left out of reset.
    always_ff @(posedge clock_i) begin
        if (wr_ok && wr_sel == SEL_P0) begin
            p0_q <= wr_data_i;
        end
    end

    assign core.core_start_o     = core_start_q;
    assign core.core_p_prime_0_o = p0_q;

    // Operand buffers present the word(s) at the next pointer value, so the
    // core outputs follow a strobe by one cycle and hold outside ARM/RUN.
    fios_word_buffer #(.DEPTH(s), .WIN(PE_NB), .AW(ADDR_W)) u_a_buf (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_en_i   (wr_ok && wr_sel == SEL_A),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (feed_en),
        .rd_base_i (32'(a_ptr_d) * 32'(PE_NB)),
        .rd_data_o (core.core_a_o)
    );

    fios_word_buffer #(.DEPTH(s), .WIN(1), .AW(ADDR_W)) u_b_buf (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_en_i   (wr_ok && wr_sel == SEL_B),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (feed_en),
        .rd_base_i (32'(b_ptr_d)),
        .rd_data_o (core.core_b_o)
    );

    fios_word_buffer #(.DEPTH(s), .WIN(1), .AW(ADDR_W)) u_p_buf (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_en_i   (wr_ok && wr_sel == SEL_P),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (feed_en),
        .rd_base_i (32'(p_ptr_d)),
        .rd_data_o (core.core_p_o)
    );

    // Result buffer: written by core pushes, read by the host in any state.
    fios_word_buffer #(.DEPTH(s), .WIN(1), .AW(ADDR_W)) u_res_buf (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_en_i   (res_we),
        .wr_addr_i (res_ptr_q[ADDR_W-1:0]),
        .wr_data_i (core.core_res_i),
        .rd_en_i   (1'b1),
        .rd_base_i (32'(rd_addr_i)),
        .rd_data_o (rd_data_o)
    );

endmodule

// File: tb/tb_fios_operand_sequencer.sv
// Directed bench for fios_operand_sequencer (s=4, PE_NB=2, plus an s=3 instance
// for the zero-filled A window). Stimulus queues cycle-stamped expectations;
// a negedge monitor compares them against the DUT outputs.
module tb_fios_operand_sequencer;
    import fios_seq_pkg::*;

    localparam int S  = 4;
    localparam int PE = 2;
    localparam int AW = 2;

    typedef enum int {SIG_BUSY, SIG_DONE, SIG_ERR, SIG_CSTART, SIG_A, SIG_B,
                      SIG_P, SIG_P0, SIG_RD, SIG_A3} sig_e;

    typedef struct {
        int          when;
        sig_e        sig;
        logic [33:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [AW-1:0]     wr_addr;
    logic [16:0]       wr_data;
    logic              start, start3;
    logic [AW-1:0]     rd_addr, rd_addr3;
    logic              busy, done, err, busy3, done3, err3;
    logic [16:0]       rd_data, rd_data3;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    fios_operand_sequencer_if #(.PE_NB(PE)) cif ();
    fios_operand_sequencer_if #(.PE_NB(PE)) cif3 ();

    fios_operand_sequencer #(.s(S), .PE_NB(PE)) dut (
        .clock_i(clk), .reset_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start),
        .busy_o(busy), .done_o(done), .err_o(err), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .core(cif)
    );

    fios_operand_sequencer #(.s(3), .PE_NB(PE)) dut3 (
        .clock_i(clk), .reset_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start3),
        .busy_o(busy3), .done_o(done3), .err_o(err3), .rd_addr_i(rd_addr3),
        .rd_data_o(rd_data3), .core(cif3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [33:0] sample(input sig_e s);
        case (s)
            SIG_BUSY:   return 34'(busy);
            SIG_DONE:   return 34'(done);
            SIG_ERR:    return 34'(err);
            SIG_CSTART: return 34'(cif.core_start_o);
            SIG_A:      return cif.core_a_o;
            SIG_B:      return 34'(cif.core_b_o);
            SIG_P:      return 34'(cif.core_p_o);
            SIG_P0:     return 34'(cif.core_p_prime_0_o);
            SIG_RD:     return 34'(rd_data);
            SIG_A3:     return cif3.core_a_o;
            default:    return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].when == cyc) begin
                check(sb[i].name, sample(sb[i].sig), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Advance to just after the next rising edge; inputs driven before it were sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect value v on signal sg during the current cycle (the one just entered).
    task automatic expect_now(input sig_e sg, input logic [33:0] v, input string name);
        exp_t e;
        e.when = cyc;
        e.sig  = sg;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [33:0] win(input logic [16:0] w1, input logic [16:0] w0);
        return {w1, w0};
    endfunction

    task automatic wr(input logic [1:0] sel, input int addr, input logic [16:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic push(input logic [16:0] v, input logic with_done);
        cif.core_res_push_i = 1'b1;
        cif.core_res_i      = v;
        cif.core_done_i     = with_done;
        step();
        cif.core_res_push_i = 1'b0;
        cif.core_done_i     = 1'b0;
    endtask

    initial begin
        logic [16:0] exp_b [5];
        exp_b = '{17'd6, 17'd7, 17'd8, 17'd5, 17'd6};

        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start3 = 1'b0; rd_addr = '0; rd_addr3 = '0;
        cif.core_a_shift_i = 1'b0; cif.core_b_fetch_i = 1'b0; cif.core_p_fetch_i = 1'b0;
        cif.core_res_push_i = 1'b0; cif.core_res_i = '0; cif.core_done_i = 1'b0;
        cif3.core_a_shift_i = 1'b0; cif3.core_b_fetch_i = 1'b0; cif3.core_p_fetch_i = 1'b0;
        cif3.core_res_push_i = 1'b0; cif3.core_res_i = '0; cif3.core_done_i = 1'b0;

        // Reset values
        step(); step();
        expect_now(SIG_BUSY, 0, "rst_busy");
        expect_now(SIG_DONE, 0, "rst_done");
        expect_now(SIG_ERR, 0, "rst_err");
        expect_now(SIG_CSTART, 0, "rst_cstart");
        expect_now(SIG_A, 0, "rst_a");
        expect_now(SIG_B, 0, "rst_b");
        expect_now(SIG_P, 0, "rst_p");
        expect_now(SIG_RD, 0, "rst_rd");
        rst = 1'b0;
        step();

        // Load operands (the s=3 instance only takes addresses 0..2 of A)
        for (int i = 0; i < 4; i++) wr(2'd0, i, 17'(i + 1));
        for (int i = 0; i < 4; i++) wr(2'd1, i, 17'(i + 5));
        for (int i = 0; i < 4; i++) wr(2'd2, i, 17'(i + 9));
        wr(2'd3, 0, 17'h1FFFF);

        // Run 1: start sequencing
        start = 1'b1; start3 = 1'b1;
        step();
        expect_now(SIG_BUSY, 1, "arm_busy");
        expect_now(SIG_CSTART, 0, "arm_cstart");
        expect_now(SIG_ERR, 0, "arm_err");
        start = 1'b0; start3 = 1'b0;
        step();
        expect_now(SIG_CSTART, 1, "run_cstart");
        expect_now(SIG_A, win(2, 1), "run_a0");
        expect_now(SIG_B, 5, "run_b0");
        expect_now(SIG_P, 9, "run_p0");
        expect_now(SIG_P0, 17'h1FFFF, "run_pprime");
        expect_now(SIG_A3, win(2, 1), "s3_a0");
        step();
        expect_now(SIG_CSTART, 0, "cstart_single");
        expect_now(SIG_BUSY, 1, "run_busy");

        // B fetches with wrap; last one also fetches P
        for (int i = 0; i < 5; i++) begin
            cif.core_b_fetch_i = 1'b1;
            cif.core_p_fetch_i = (i == 4);
            step();
            expect_now(SIG_B, 34'(exp_b[i]), "b_step");
            if (i == 4) expect_now(SIG_P, 10, "p_step");
        end
        cif.core_b_fetch_i = 1'b0;
        cif.core_p_fetch_i = 1'b0;

        // A window shifts with wrap; s=3 instance zero-fills its upper word
        cif.core_a_shift_i = 1'b1; cif3.core_a_shift_i = 1'b1;
        step();
        expect_now(SIG_A, win(4, 3), "a_win1");
        expect_now(SIG_A3, win(0, 3), "s3_a_zero_fill");
        cif3.core_a_shift_i = 1'b0;
        step();
        expect_now(SIG_A, win(2, 1), "a_wrap");
        cif.core_a_shift_i = 1'b0;

        // Four pushes, the last together with done
        push(17'h1ABCD, 1'b0);
        push(17'd2, 1'b0);
        push(17'd3, 1'b0);
        push(17'd4, 1'b1);
        expect_now(SIG_DONE, 1, "done_pulse");
        expect_now(SIG_ERR, 0, "done_ok_err");
        expect_now(SIG_BUSY, 0, "done_busy");
        rd_addr = 2'd0;
        step();
        expect_now(SIG_RD, 17'h1ABCD, "rd0");
        expect_now(SIG_DONE, 0, "done_one_cycle");
        rd_addr = 2'd3;
        step();
        expect_now(SIG_RD, 4, "rd3_same_cycle_push");

        // Run 2: short result count
        start = 1'b1;
        step();
        expect_now(SIG_BUSY, 1, "r2_busy");
        start = 1'b0;
        step();
        push(17'h11, 1'b0);
        push(17'h12, 1'b0);
        push(17'h13, 1'b0);
        cif.core_done_i = 1'b1;
        step();
        cif.core_done_i = 1'b0;
        expect_now(SIG_DONE, 1, "r2_done");
        expect_now(SIG_ERR, 1, "r2_short_err");
        step();
        expect_now(SIG_ERR, 1, "r2_err_sticky");
        rd_addr = 2'd1;
        step();
        expect_now(SIG_RD, 17'h12, "r2_rd1");
        rd_addr = 2'd3;
        step();
        expect_now(SIG_RD, 4, "r2_rd3_kept");
        start = 1'b1;
        step();
        expect_now(SIG_ERR, 0, "start_clears_err");
        start = 1'b0;
        step();

        // Run 3: write while running, then reset mid-run
        wr(2'd0, 0, 17'h55);
        expect_now(SIG_ERR, 1, "busy_write_err");
        rst = 1'b1;
        step();
        expect_now(SIG_BUSY, 0, "midrst_busy");
        expect_now(SIG_ERR, 0, "midrst_err");
        expect_now(SIG_A, 0, "midrst_a");
        expect_now(SIG_B, 0, "midrst_b");
        rst = 1'b0;
        cif.core_b_fetch_i = 1'b1; cif.core_a_shift_i = 1'b1;
        cif.core_res_push_i = 1'b1; cif.core_res_i = 17'h77; cif.core_done_i = 1'b1;
        step();
        cif.core_b_fetch_i = 1'b0; cif.core_a_shift_i = 1'b0;
        cif.core_res_push_i = 1'b0; cif.core_done_i = 1'b0;
        step();
        expect_now(SIG_DONE, 0, "postrst_no_done");
        expect_now(SIG_BUSY, 0, "postrst_busy");
        expect_now(SIG_ERR, 0, "postrst_err");
        expect_now(SIG_B, 0, "postrst_b");
        rd_addr = 2'd0;
        step();
        expect_now(SIG_RD, 17'h11, "postrst_push_ignored");

        // Run 4: dropped write confirmed, then result overflow
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        expect_now(SIG_A, win(2, 1), "r4_a_unchanged");
        expect_now(SIG_B, 5, "r4_b_restart");
        expect_now(SIG_CSTART, 1, "r4_cstart");
        for (int i = 0; i < 5; i++) begin
            push(17'(32'h21 + i), 1'b0);
            if (i == 3) expect_now(SIG_ERR, 0, "r4_full_no_err");
            if (i == 4) expect_now(SIG_ERR, 1, "r4_overflow_err");
        end
        cif.core_done_i = 1'b1;
        step();
        cif.core_done_i = 1'b0;
        expect_now(SIG_DONE, 1, "r4_done");
        expect_now(SIG_ERR, 1, "r4_err_kept");
        rd_addr = 2'd3;
        step();
        expect_now(SIG_RD, 17'h24, "r4_overflow_dropped");
        rd_addr = 2'd0;
        step();
        expect_now(SIG_RD, 17'h21, "r4_rd0");

        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expectations never compared, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fios_operand_sequencer.md
Name: fios_operand_sequencer

Overview:
- Front-end controller for the FIOS 3A Montgomery multiplier core. It buffers the A, B and P operands (s words of 17 bits each) written by the host and issues the start pulse to the core.
- It serves the core's b_fetch/p_fetch strobes and presents the folded A window, advancing it on a_shift. It also collects RES_push words into a result buffer and reports completion.
- It sits between the host/bus register file and the FIOS top, and owns all operand storage and sequencing for one multiplication at a time.

Parameters:
- s, 8, number of 17-bit words per operand.
- PE_NB, 8, number of PEs, i.e. A words presented per window. Must be between 1 and s.
- ADDR_W, $clog2(s), width of the word address for writes and result reads.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  operand word write strobe.
- wr_sel_i  in  2  write target: 0=A, 1=B, 2=P, 3=P'0 (address ignored).
- wr_addr_i  in  ADDR_W  operand word index.
- wr_data_i  in  17  operand word.
- start_i  in  1  host request to start one multiplication.
- busy_o  out  1  multiplication in progress.
- done_o  out  1  one-cycle pulse when results are complete.
- err_o  out  1  sticky error flag; cleared by the next accepted start_i.
- rd_addr_i  in  ADDR_W  result word index.
- rd_data_o  out  17  result word, 1-cycle read latency.
- core_start_o  out  1  start pulse to the core.
- core_p_prime_0_o  out  17  P'0 word to the core.
- core_a_o  out  PE_NB*17  current A window; word 0 is in the LSBs.
- core_b_o  out  17  current B word.
- core_p_o  out  17  current P word.
- core_a_shift_i  in  1  core requests the next A window.
- core_b_fetch_i  in  1  core consumed the B word.
- core_p_fetch_i  in  1  core consumed the P word.
- core_res_push_i  in  1  core result word is valid.
- core_res_i  in  17  core result word.
- core_done_i  in  1  core finished.

Behaviour:
- Reset: the FSM goes to IDLE and all pointers are 0. busy_o=0, done_o=0, err_o=0, core_start_o=0. core_a_o, core_b_o, core_p_o and rd_data_o are 0. Operand and result buffer contents are not cleared.
- Reset mid-operation aborts the run in the same edge. Core strobes arriving after reset are ignored until the next start.
- FSM states:
  - IDLE: writes are accepted. start_i moves to ARM. err_o is cleared. a_ptr, b_ptr, p_ptr, res_ptr and the push count are zeroed.
  - ARM (1 cycle): registers A window 0, B[0] and P[0] onto the core outputs. busy_o=1. Moves to RUN.
  - RUN: core_start_o pulses high for exactly the first RUN cycle, i.e. 2 cycles after start_i. Core strobes are serviced here.
  - DONE (1 cycle): done_o=1, busy_o=0. Moves to IDLE.
- Writes: wr_en_i is honoured only in IDLE. A write while busy_o=1 is dropped and sets err_o. wr_addr_i >= s is dropped and sets err_o.
- start_i is ignored outside IDLE and sets no error.
- B/P service:
  - On core_b_fetch_i, b_ptr advances to (b_ptr+1) mod s. core_b_o shows B[new b_ptr] on the next cycle. p behaves identically and independently.
  - Both strobes in the same cycle advance both pointers.
- A window:
  - Word k of core_a_o = A[a_ptr*PE_NB+k], or 0 if that index is >= s.
  - core_a_shift_i increments a_ptr. a_ptr wraps to 0 after ceil(s/PE_NB)-1. The new window is visible next cycle.
- Results:
  - core_res_push_i writes core_res_i to RES[res_ptr] and increments res_ptr, saturating at s.
  - A push beyond s words sets err_o and the word is dropped.
- Completion:
  - core_done_i in RUN moves to DONE. A push in the same cycle as done is still captured.
  - If the total pushes are not equal to s at done, err_o is set.
  - core_done_i outside RUN is ignored.
- Result read: rd_data_o = RES[rd_addr_i] registered, valid in any state. Reading during RUN returns the partial buffer.

Decomposition:
- Package fios_seq_pkg:
  - state enum {IDLE, ARM, RUN, DONE}.
  - wr_sel encodings (A, B, P, P0).
  - WORD_W=17.
- Sub-module fios_word_buffer: s x 17 register array with a write port, a registered read port and a combinational window read. It is instantiated for A, B, P and RES.

Test Plan (s=4, PE_NB=2 unless noted):
- Load A={1,2,3,4}, B={5,6,7,8}, P={9,10,11,12}, then pulse start_i -> busy_o=1 next cycle; core_start_o high 2 cycles after start_i; core_a_o={2,1} (word 1, word 0); core_b_o=5; core_p_o=9.
- 5 b_fetch pulses -> core_b_o steps 6,7,8,5,6 (wrap at s). 2 a_shift pulses -> window {4,3} then {2,1}.
- s=3, PE_NB=2, A={1,2,3}: one a_shift -> window {0,3} (upper word zero-filled).
- 4 pushes of 0x1ABCD, 2, 3, 4, then core_done_i -> done_o pulses 1 cycle; err_o=0; rd_addr_i=0 gives 0x1ABCD one cycle later.
- core_done_i after only 3 pushes -> err_o=1 sticky; next start_i clears it.
- wr_en_i during RUN -> write dropped, err_o=1. reset_i mid-RUN -> IDLE next cycle, busy_o=0, core strobes ignored afterwards.
